// File: rtl/simplebus_pkg.sv
// Shared constants, state encoding and parity helper for the simplebus master.
package simplebus_pkg;

  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_WRITE = 8'h03;
  localparam logic [7:0] ACK_READ  = 8'h82;
  localparam logic [7:0] ACK_WRITE = 8'h83;

  localparam int ADDR_BYTES = 4;
  localparam int DATA_BYTES = 8;
  // Bytes that follow the command byte: address, sel, write data (reads stop after address).
  localparam int TX_TAIL_BYTES = ADDR_BYTES + 1 + DATA_BYTES;
  localparam int TX_SHIFT_W    = TX_TAIL_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT_ACK,
    ST_RX_DATA,
    ST_RESP
  } state_t;

  function automatic logic bus_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/simplebus_rr_arb2.sv
// Two-way round-robin arbiter: pointer starts at requester 0 and moves to the
// loser after every grant taken with the advance strobe.
module simplebus_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_reg;

  always_comb begin
    grant = 2'b00;
    if (valid[ptr_reg]) begin
      grant[ptr_reg] = 1'b1;
    end else if (valid[~ptr_reg]) begin
      grant[~ptr_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr_reg <= ~grant[1];
    end
  end

endmodule

// File: rtl/simplebus_master_arb.sv
// Two-requester master for the 8-bit parity-protected simplebus.
// Optional device parity checking is enabled with SIMPLEBUS_PARITY_CHECK_EN.
module simplebus_master_arb
  import simplebus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int NUM_REQ        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [32*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0]  req_sel,
  input  logic [64*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [63:0]           resp_rdata,
  output logic                  resp_err,
  output logic [7:0]            ext_bus_out,
  output logic                  ext_bus_pty_out,
  input  logic [7:0]            ext_bus_in,
  input  logic                  ext_bus_pty_in
);

  localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES);

  state_t state_reg, state_next;

  logic [3:0]            cnt_reg;
  logic [15:0]           timer_reg;
  logic [TX_SHIFT_W-1:0] tx_shift_reg;
  logic [7:0]            bus_out_reg;
  logic [63:0]           rdata_reg;
  logic                  err_reg;
  logic                  owner_reg;
  logic                  we_reg;

  logic [1:0]  grant;
  logic        gidx;
  logic [31:0] addr_arr  [NUM_REQ];
  logic [7:0]  sel_arr   [NUM_REQ];
  logic [63:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[32*gi +: 32];
    assign sel_arr[gi]   = req_sel[8*gi +: 8];
    assign wdata_arr[gi] = req_wdata[64*gi +: 64];
  end

  simplebus_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (state_reg == ST_IDLE),
    .grant   (grant)
  );

  assign gidx = grant[1];

  logic pty_bad;
`ifdef SIMPLEBUS_PARITY_CHECK_EN
  assign pty_bad = (ext_bus_pty_in != bus_parity(ext_bus_in));
`else
  logic unused_pty;
  assign unused_pty = ext_bus_pty_in;
  assign pty_bad    = 1'b0;
`endif

  // A WAIT_ACK cycle ends on any nonzero byte, a parity error or the last timeout tick.
  logic [7:0] exp_ack;
  logic       byte_zero;
  logic       wait_done;
  logic       wait_err;

  assign exp_ack   = we_reg ? ACK_WRITE : ACK_READ;
  assign byte_zero = (ext_bus_in == 8'h00);
  assign wait_done = pty_bad || !byte_zero || (timer_reg == 16'd1);
  assign wait_err  = pty_bad || (!byte_zero && (ext_bus_in != exp_ack)) ||
                     (byte_zero && (timer_reg == 16'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = rst_n ? grant : '0;
        if (grant != 2'b00) state_next = ST_TX;
      end
      ST_TX: begin
        if (cnt_reg == 4'd0) state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (wait_done) state_next = (wait_err || we_reg) ? ST_RESP : ST_RX_DATA;
      end
      ST_RX_DATA: begin
        if (cnt_reg == 4'd0) state_next = ST_RESP;
      end
      ST_RESP: begin
        state_next            = ST_IDLE;
        resp_valid[owner_reg] = 1'b1;
        resp_rdata            = err_reg ? 64'd0 : rdata_reg;
        resp_err              = err_reg;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      timer_reg    <= '0;
      tx_shift_reg <= '0;
      bus_out_reg  <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      owner_reg    <= 1'b0;
      we_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            owner_reg    <= gidx;
            we_reg       <= req_we[gidx];
            bus_out_reg  <= req_we[gidx] ? CMD_WRITE : CMD_READ;
            tx_shift_reg <= {wdata_arr[gidx], sel_arr[gidx], addr_arr[gidx]};
            cnt_reg      <= req_we[gidx] ? 4'(TX_TAIL_BYTES) : 4'(ADDR_BYTES);
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
          end
        end
        ST_TX: begin
          if (cnt_reg == 4'd0) begin
            bus_out_reg <= 8'h00;
            timer_reg   <= TIMEOUT_LOAD;
          end else begin
            bus_out_reg  <= tx_shift_reg[7:0];
            tx_shift_reg <= tx_shift_reg >> 8;
            cnt_reg      <= cnt_reg - 4'd1;
          end
        end
        ST_WAIT_ACK: begin
          timer_reg <= timer_reg - 16'd1;
          if (wait_err) err_reg <= 1'b1;
          if (wait_done && !wait_err && !we_reg) cnt_reg <= 4'(DATA_BYTES - 1);
        end
        ST_RX_DATA: begin
          rdata_reg <= {ext_bus_in, rdata_reg[63:8]};
          cnt_reg   <= cnt_reg - 4'd1;
          if (pty_bad) err_reg <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign ext_bus_out     = bus_out_reg;
  assign ext_bus_pty_out = bus_parity(bus_out_reg);

endmodule

// File: tb/tb_simplebus_master_arb.sv
// Self-checking bench for simplebus_master_arb: directed cases then random traffic
// against a byte-level model of the bus protocol and round-robin grant order.
module tb_simplebus_master_arb;

  localparam int T = 16;
`ifdef SIMPLEBUS_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_we, req_ready, resp_valid;
  logic [63:0]  req_addr;
  logic [15:0]  req_sel;
  logic [127:0] req_wdata;
  logic [63:0]  resp_rdata;
  logic         resp_err;
  logic [7:0]   ext_bus_out, ext_bus_in;
  logic         ext_bus_pty_out, ext_bus_pty_in;

  simplebus_master_arb #(.TIMEOUT_CYCLES(T), .NUM_REQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_sel(req_sel), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ext_bus_out(ext_bus_out), .ext_bus_pty_out(ext_bus_pty_out),
    .ext_bus_in(ext_bus_in), .ext_bus_pty_in(ext_bus_pty_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Requester fields and device behaviour for the next transaction.
  logic        f_we    [2];
  logic [31:0] f_addr  [2];
  logic [7:0]  f_sel   [2];
  logic [63:0] f_wdata [2];
  int          dev_delay;
  int          dev_mode;   // 0 good ACK, 1 swapped ACK, 2 junk byte, 3 silent
  int          dev_flip;   // data byte index with bad parity, -1 none
  logic [7:0]  dev_junk;
  logic [7:0]  dev_data [8];
  int          rr_model = 0;
  int          act_gi;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_dev(input logic [7:0] b, input bit flip);
    ext_bus_in     = b;
    ext_bus_pty_in = (~^b) ^ flip;
  endtask

  task automatic pack_fields();
    for (int i = 0; i < 2; i++) begin
      req_we[i]               = f_we[i];
      req_addr[32*i +: 32]    = f_addr[i];
      req_sel[8*i +: 8]       = f_sel[i];
      req_wdata[64*i +: 64]   = f_wdata[i];
    end
  endtask

  // Present the mask, follow one transaction end to end, check every observable.
  task automatic run_txn(input logic [1:0] mask);
    int         gi, g, n, exp_cyc;
    bit         ok, data_phase, exp_err;
    logic [1:0] exp_grant;
    logic [7:0] frame[$];
    logic [7:0] ack_b;
    logic [63:0] exp_rdata;

    gi = mask[rr_model] ? rr_model : 1 - rr_model;
    pack_fields();
    req_valid = mask;
    drive_dev(8'h00, 1'b0);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      #1;
      if (req_ready != 2'b00) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("grant_seen", 64'(ok), 64'd1);
    if (!ok) begin req_valid = 2'b00; return; end
    exp_grant = 2'b00;
    exp_grant[gi] = 1'b1;
    check("grant_idx", 64'(req_ready), 64'(exp_grant));
    act_gi   = int'(req_ready[1]);
    rr_model = 1 - gi;
    g = cyc;

    frame.push_back(f_we[gi] ? 8'h03 : 8'h02);
    for (int k = 0; k < 4; k++) frame.push_back(f_addr[gi][8*k +: 8]);
    if (f_we[gi]) begin
      frame.push_back(f_sel[gi]);
      for (int k = 0; k < 8; k++) frame.push_back(f_wdata[gi][8*k +: 8]);
    end
    n = frame.size();

    case (dev_mode)
      0:       ack_b = f_we[gi] ? 8'h83 : 8'h82;
      1:       ack_b = f_we[gi] ? 8'h82 : 8'h83;
      default: ack_b = dev_junk;
    endcase
    data_phase = (dev_mode == 0) && !f_we[gi];
    exp_err    = (dev_mode != 0) || (data_phase && dev_flip >= 0 && PCHK);
    exp_rdata  = '0;
    if (data_phase && !exp_err)
      for (int k = 0; k < 8; k++) exp_rdata[8*k +: 8] = dev_data[k];
    if (dev_mode == 3) exp_cyc = g + n + 1 + T;
    else               exp_cyc = g + n + 1 + dev_delay + 1 + (data_phase ? 8 : 0);

    @(negedge clk);
    req_valid[gi] = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("tx_byte%0d", i), 64'(ext_bus_out), 64'(frame[i]));
      check("tx_pty", 64'(ext_bus_pty_out), 64'(~^frame[i]));
      @(negedge clk);
    end
    check("tx_idle", 64'(ext_bus_out), 64'd0);

    if (dev_mode != 3) begin
      for (int d = 0; d < dev_delay; d++) @(negedge clk);
      drive_dev(ack_b, 1'b0);
      @(negedge clk);
      drive_dev(8'h00, 1'b0);
      if (data_phase) begin
        for (int k = 0; k < 8; k++) begin
          drive_dev(dev_data[k], k == dev_flip);
          @(negedge clk);
        end
        drive_dev(8'h00, 1'b0);
      end
    end

    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (resp_valid != 2'b00) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("resp_seen", 64'(ok), 64'd1);
    if (!ok) return;
    check("resp_cycle", 64'(cyc), 64'(exp_cyc));
    check("resp_owner", 64'(resp_valid), 64'(exp_grant));
    check("resp_err", 64'(resp_err), 64'(exp_err));
    check("resp_rdata", resp_rdata, exp_rdata);
    $display("[TB] txn req=%0d we=%0d addr=%08h mode=%0d err=%0d rdata=%016h", gi, f_we[gi],
             f_addr[gi], dev_mode, resp_err, resp_rdata);
    @(negedge clk);
    check("resp_pulse", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int cnt0, cnt1, prev_gi;
    rst_n = 1'b0;
    req_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      f_we[i] = 1'b0; f_addr[i] = '0; f_sel[i] = '0; f_wdata[i] = '0;
    end
    pack_fields();
    drive_dev(8'h00, 1'b0);
    dev_delay = 0; dev_mode = 0; dev_flip = -1; dev_junk = 8'h11;
    repeat (3) @(negedge clk);
    check("rst_bus", 64'(ext_bus_out), 64'd0);
    check("rst_pty", 64'(ext_bus_pty_out), 64'd1);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed write from requester 0.
    f_we[0] = 1'b1; f_addr[0] = 32'h12345678; f_sel[0] = 8'hFF; f_wdata[0] = 64'h1122334455667788;
    dev_delay = 3; dev_mode = 0;
    run_txn(2'b01);

    // Directed read from requester 1, device idle for 8 cycles.
    f_we[1] = 1'b0; f_addr[1] = 32'h00001000;
    for (int k = 0; k < 8; k++) dev_data[k] = 8'(8 - k);
    dev_delay = 8;
    run_txn(2'b10);

    // Both valid: 4 reads each, grants must alternate.
    cnt0 = 4; cnt1 = 4; prev_gi = -1;
    while (cnt0 + cnt1 > 0) begin
      for (int i = 0; i < 2; i++) begin f_we[i] = 1'b0; f_addr[i] = $urandom; end
      for (int k = 0; k < 8; k++) dev_data[k] = 8'($urandom);
      dev_delay = $urandom_range(0, 6);
      run_txn({cnt1 > 0, cnt0 > 0});
      if (prev_gi >= 0 && cnt0 > 0 && cnt1 > 0) check("alternate", 64'(act_gi), 64'(1 - prev_gi));
      prev_gi = act_gi;
      if (act_gi == 0) cnt0--; else cnt1--;
    end

    // Silent device: timeout, then a normal write is still served.
    f_we[0] = 1'b0; f_addr[0] = 32'hDEAD0000; dev_mode = 3;
    run_txn(2'b01);
    f_we[1] = 1'b1; f_addr[1] = 32'h00000040; f_sel[1] = 8'h0F; f_wdata[1] = 64'hCAFEF00D12345678;
    dev_mode = 0; dev_delay = 2;
    run_txn(2'b10);

    // Write ACK returned to a read.
    f_we[0] = 1'b0; f_addr[0] = 32'h00000080; dev_mode = 1; dev_delay = 1;
    run_txn(2'b01);

    // Bad parity on data byte 3.
    f_we[1] = 1'b0; f_addr[1] = 32'h00002000; dev_mode = 0; dev_delay = 0; dev_flip = 3;
    for (int k = 0; k < 8; k++) dev_data[k] = 8'($urandom);
    run_txn(2'b10);
    dev_flip = -1;

    // Random traffic.
    for (int it = 0; it < 20; it++) begin
      int r;
      for (int i = 0; i < 2; i++) begin
        f_we[i] = 1'($urandom_range(0, 1)); f_addr[i] = $urandom;
        f_sel[i] = 8'($urandom); f_wdata[i] = {$urandom, $urandom};
      end
      for (int k = 0; k < 8; k++) dev_data[k] = 8'($urandom);
      dev_delay = $urandom_range(0, 12);
      r = $urandom_range(0, 9);
      dev_mode = (r < 7) ? 0 : r - 6;
      dev_junk = 8'($urandom_range(1, 127));
      run_txn(2'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
